// File: rtl/chunk_serial_adder.sv
// Multi-cycle WIDTH-bit adder that time-multiplexes one 2-bit full-adder slice.
// Start/done handshake; one 2-bit chunk per clock, LSB first.
module fa2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);
    assign {cout, sum} = 3'(a) + 3'(b) + 3'(cin);
endmodule

module chunk_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (WIDTH > 2) ? WIDTH - 2 : 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [RW-1:0]    res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    count;
    logic [1:0]       s2;
    logic             c2;
    logic             last;

    fa2_slice u_slice (
        .a    (a_sh[1:0]),
        .b    (b_sh[1:0]),
        .cin  (carry),
        .sum  (s2),
        .cout (c2)
    );

    assign last = (count == CW'(N - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Partial result holds only the chunks already produced; the new chunk enters at the top.
    generate
        if (WIDTH == 2) begin : g_narrow
            assign res_nxt = s2;
        end else begin : g_wide
            assign res_nxt = {s2, res_sh};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != RUN && start) begin
                a_sh   <= a;
                b_sh   <= b;
                carry  <= cin;
                res_sh <= '0;
                count  <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 2;
                b_sh   <= b_sh >> 2;
                res_sh <= res_nxt[WIDTH-1 -: RW];
                carry  <= c2;
                count  <= count + 1'b1;
                if (last) begin
                    sum  <= res_nxt;
                    cout <= c2;
                end
            end
        end
    end
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder: per-cycle model compare on an
// 8-bit instance plus an exhaustive sweep of a 2-bit instance.
module tb_chunk_serial_adder;
    localparam int N8 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int checks = 0;
    int errors = 0;

    chunk_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    chunk_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges counted since reset; accept edge e0; result due at edge e0+N.
    int unsigned e = 0;
    int unsigned e0 = 0;
    bit          act = 1'b0;
    bit          in_run;
    logic [8:0]  pend = '0;
    logic [8:0]  outv = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act  = 1'b0;
            outv = '0;
            e    = 0;
        end else begin
            e++;
            in_run = act && (e - e0) >= 1 && (e - e0) <= N8;
            if (in_run && (e - e0) == N8) outv = pend;
            if (start && !in_run) begin
                act  = 1'b1;
                e0   = e;
                pend = 9'(a) + 9'(b) + 9'(cin);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(act && (e - e0) < N8));
        check("done", 32'(done), 32'(act && (e - e0) == N8));
        check("result", 32'({cout, sum}), 32'(outv));
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, output int lat);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; cin = ic;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
        wait_done(lat);
    endtask

    int lat;
    int ndone;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'({cout, sum}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hFF, 8'h01, 1'b0, lat);
        check("lat_ff01", 32'(lat), 32'd4);
        check("res_ff01", 32'({cout, sum}), 32'h100);

        run_op(8'hAA, 8'h55, 1'b1, lat);
        check("res_aa55", 32'({cout, sum}), 32'h100);
        repeat (3) @(negedge clk);
        check("hold_idle", 32'({cout, sum}), 32'h100);
        run_op(8'h00, 8'h00, 1'b0, lat);
        check("res_zero", 32'({cout, sum}), 32'h000);

        // Start pulsed mid-run must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("hold_run", 32'({cout, sum}), 32'h000);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (i == 1) check("ign_done_at_e4", 32'(done), 32'd1);
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_res", 32'({cout, sum}), 32'h046);

        // Asynchronous reset between E2 and E3.
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", 32'({cout, sum}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_nodone", 32'(ndone), 32'd0);
        run_op(8'h3C, 8'h0F, 1'b0, lat);
        check("lat_3c0f", 32'(lat), 32'd4);
        check("res_3c0f", 32'({cout, sum}), 32'h04B);

        // Back-to-back accept during the done cycle.
        run_op(8'h80, 8'h80, 1'b0, lat);
        check("res_8080", 32'({cout, sum}), 32'h100);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("lat_b2b", 32'(lat), 32'd4);
        check("res_b2b", 32'({cout, sum}), 32'h047);

        // Random traffic, including starts during busy and back-to-back.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = $urandom; b = $urandom; cin = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // WIDTH=2 exhaustive sweep.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            start2 = 1'b1; a2 = 2'(i >> 3); b2 = 2'(i >> 1); cin2 = i[0];
            @(negedge clk);
            start2 = 1'b0;
            check("w2_busy", 32'(busy2), 32'd1);
            lat = 0;
            while (!done2 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("w2_lat", 32'(lat), 32'd1);
            check("w2_res", 32'({cout2, sum2}), 32'(i >> 3) + 32'((i >> 1) & 3) + 32'(i & 1));
        end
        @(negedge clk);
        start2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        check("w2_done_111", 32'(done2), 32'd1);
        check("w2_res_111", 32'({cout2, sum2}), 32'b111);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/chunk_serial_adder.md
Name: chunk_serial_adder

Overview:
- Multi-cycle N-bit adder built around the team's 2-bit full-adder slice.
- Sits directly upstream of the 2-bit full adder and drives it. Each cycle it feeds one 2-bit operand chunk plus the registered carry into the slice. It collects the slice's sum and cout back into a result register.
- Start/done handshake, so wide additions use one 2-bit adder instead of a WIDTH-bit ripple chain.

Parameters:
- WIDTH, default 8: operand width in bits. Must be even and >= 2. N = WIDTH/2 = number of slice cycles.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while the addition is in progress (RUN).
- done  output  1  one-cycle pulse: sum/cout just updated.
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out (bit WIDTH of a+b+cin).

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, carry and count registers = 0.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Start acceptance:
  - start is accepted at an edge where state is IDLE or DONE; call that edge E0.
  - On E0: capture a, b into shift registers, cin into the carry register; count=0; next state RUN.
  - start is ignored while in RUN; operands and result are unaffected.
- RUN, each edge E1..EN:
  - Slice inputs are the low 2 bits of A_sh, the low 2 bits of B_sh, and the carry register.
  - Slice outputs are a 2-bit sum and a cout.
  - A_sh and B_sh shift right by 2.
  - The 2-bit slice sum shifts into the top of the result shift register (result shifts right by 2).
  - The carry register takes the slice cout; count increments.
- Edge EN (count reaches N-1 before the edge): load the final result into sum and the final carry into cout; next state DONE. done is therefore high for the single cycle following EN.
- Latency: done asserts N cycles after the accepting edge E0. Example: WIDTH=8 gives 4 cycles; WIDTH=2 gives 1 cycle.
- DONE: lasts exactly one cycle. With no start, next state is IDLE. With start, a new operation is accepted (back-to-back; DONE acts as the E0 state).
- Hold rule: sum and cout change only at the EN edge or on reset. They hold their values through IDLE and through a following RUN until that run's EN.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), exact; no saturation. The slice is a pure combinational 2-bit adder; all carry storage is in this block.
- Reset mid-operation: immediate abort to IDLE with all outputs 0; no done pulse for the aborted operation. The next start after rst_n rises operates normally.
- No X propagation: a, b, cin are don't-care except at the accepting edge.

Test Plan:
- WIDTH=8: start with a=0xFF, b=0x01, cin=0 -> busy high for 4 cycles; done pulses 4 cycles after accept; sum=0x00, cout=1.
- WIDTH=8: a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0. sum/cout hold between operations.
- Start ignored while busy: accept a=0x12, b=0x34, cin=0. Pulse start at E2 with a=0xFF, b=0xFF -> single done at E4 with sum=0x46, cout=0; no second done.
- Async reset mid-operation: drop rst_n between E2 and E3 -> busy, done, sum, cout all 0 immediately; no done follows. After release, start with a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0 after 4 cycles.
- Back-to-back: a=0x80, b=0x80, cin=0 gives done with sum=0x00, cout=1. Assert start during that done cycle with a=0x12, b=0x34, cin=1 -> busy the next cycle; second done 4 cycles later with sum=0x47, cout=0.
- WIDTH=2 build: a=2'b11, b=2'b11, cin=1 -> done 1 cycle after accept; sum=2'b11, cout=1. Exhaustive sweep of all 32 input combinations matches a+b+cin.
